// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU op and branch-type encodings,
// instruction-format tags and the NOP/IDLE words. No ports.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALUOP_ADD    = 5'd0;
  localparam logic [4:0] ALUOP_SUB    = 5'd1;
  localparam logic [4:0] ALUOP_SLL    = 5'd2;
  localparam logic [4:0] ALUOP_SLT    = 5'd3;
  localparam logic [4:0] ALUOP_SLTU   = 5'd4;
  localparam logic [4:0] ALUOP_XOR    = 5'd5;
  localparam logic [4:0] ALUOP_SRL    = 5'd6;
  localparam logic [4:0] ALUOP_SRA    = 5'd7;
  localparam logic [4:0] ALUOP_OR     = 5'd8;
  localparam logic [4:0] ALUOP_AND    = 5'd9;
  // MUL..REMU are contiguous in funct3 order.
  localparam logic [4:0] ALUOP_MUL    = 5'd10;
  localparam logic [4:0] ALUOP_MULH   = 5'd11;
  localparam logic [4:0] ALUOP_MULHSU = 5'd12;
  localparam logic [4:0] ALUOP_MULHU  = 5'd13;
  localparam logic [4:0] ALUOP_DIV    = 5'd14;
  localparam logic [4:0] ALUOP_DIVU   = 5'd15;
  localparam logic [4:0] ALUOP_REM    = 5'd16;
  localparam logic [4:0] ALUOP_REMU   = 5'd17;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JMP  = 3'd7;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] IDLE = 32'b0;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_t;

  // Base integer ALU op from funct3; alt selects SUB/SRA.
  function automatic logic [4:0] base_aluop(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALUOP_SUB : ALUOP_ADD;
      3'b001:  op = ALUOP_SLL;
      3'b010:  op = ALUOP_SLT;
      3'b011:  op = ALUOP_SLTU;
      3'b100:  op = ALUOP_XOR;
      3'b101:  op = alt ? ALUOP_SRA : ALUOP_SRL;
      3'b110:  op = ALUOP_OR;
      default: op = ALUOP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator.
//  inst : 32-bit instruction word
//  imm  : sign-extended immediate (I/S/B/U/J), 0 for R-type/unknown opcodes
//  fmt  : instruction format selected from the opcode
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm,
  output fmt_t        fmt
);

  always_comb begin
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
      OPC_JAL:                                   fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM,
      OPC_FENCE, OPC_SYSTEM:                     fmt = FMT_I;
      OPC_STORE:                                 fmt = FMT_S;
      OPC_BRANCH:                                fmt = FMT_B;
      default:                                   fmt = FMT_R;
    endcase
  end

  always_comb begin
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'b0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage with registered output slot.
//  clk, rst          : clock, synchronous active-high reset
//  if_valid/if_ready : handshake with fetch (inst, pc)
//  rs1/rs2_addr/data : combinational regfile read port
//  flush             : EX redirect, kills the slot and the incoming instruction
//  ex_valid/ex_ready : handshake with execute
//  ex_*              : decoded fields (aluop, operands, imm, rd, wreg, load,
//                      branch type/target, pc, illegal)
// Load-use hazards stall fetch and insert a bubble (LU_STALL=1).
module id_stage
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned ALUOP_W  = 5,
  parameter bit          EN_M     = 1'b0,
  parameter bit          LU_STALL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [31:0]        inst,
  input  logic [PC_W-1:0]    pc,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  input  logic [31:0]        rs1_data,
  input  logic [31:0]        rs2_data,
  input  logic               flush,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [31:0]        ex_op1,
  output logic [31:0]        ex_op2,
  output logic [31:0]        ex_imm,
  output logic [4:0]         ex_rd,
  output logic               ex_wreg,
  output logic               ex_is_load,
  output logic [2:0]         ex_br_type,
  output logic [PC_W-1:0]    ex_br_tgt,
  output logic [PC_W-1:0]    ex_pc,
  output logic               ex_illegal
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd_f;
  logic [31:0]     imm;
  fmt_t            fmt;
  logic [PC_W-1:0] imm_pc;
  logic [31:0]     jalr_sum;

  logic [4:0]      d_aluop;
  logic [31:0]     d_op1;
  logic [31:0]     d_op2;
  logic [4:0]      d_rd;
  logic            d_wreg;
  logic            d_load;
  logic [2:0]      d_br;
  logic [PC_W-1:0] d_tgt;
  logic            d_ill;

  logic            use_rs1;
  logic            use_rs2;
  logic            hazard;
  logic            stall;
  logic            fire;
  logic [0:0]      state;

  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign rd_f     = inst[11:7];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  imm_gen u_imm_gen (
    .inst (inst),
    .imm  (imm),
    .fmt  (fmt)
  );

  assign imm_pc   = PC_W'($signed(imm));
  assign jalr_sum = rs1_data + imm;

  always_comb begin
    d_aluop = ALUOP_ADD;
    d_op1   = rs1_data;
    d_op2   = imm;
    d_wreg  = 1'b0;
    d_load  = 1'b0;
    d_br    = BR_NONE;
    d_ill   = 1'b0;
    d_tgt   = pc + imm_pc;
    case (opcode)
      OPC_LUI: begin
        d_op1  = '0;
        d_wreg = 1'b1;
      end
      OPC_AUIPC: begin
        d_op1  = 32'(pc);
        d_wreg = 1'b1;
      end
      OPC_JAL: begin
        d_op1  = 32'(pc);
        d_wreg = 1'b1;
        d_br   = BR_JMP;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          d_op1  = 32'(pc);
          d_wreg = 1'b1;
          d_br   = BR_JMP;
          d_tgt  = PC_W'({jalr_sum[31:1], 1'b0});
        end else begin
          d_ill = 1'b1;
        end
      end
      OPC_BRANCH: begin
        d_op2   = rs2_data;
        d_aluop = ALUOP_SUB;
        case (f3)
          3'b000:  d_br = BR_BEQ;
          3'b001:  d_br = BR_BNE;
          3'b100:  d_br = BR_BLT;
          3'b101:  d_br = BR_BGE;
          3'b110:  d_br = BR_BLTU;
          3'b111:  d_br = BR_BGEU;
          default: d_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_wreg = 1'b1;
        d_load = 1'b1;
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) d_ill = 1'b1;
      end
      OPC_STORE: begin
        if (f3 > 3'b010) d_ill = 1'b1;
      end
      OPC_OPIMM: begin
        d_wreg  = 1'b1;
        d_aluop = base_aluop(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001 && f7 != 7'b0000000) d_ill = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) d_ill = 1'b1;
      end
      OPC_OP: begin
        d_op2  = rs2_data;
        d_wreg = 1'b1;
        if (f7 == 7'b0000000) begin
          d_aluop = base_aluop(f3, 1'b0);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          d_aluop = base_aluop(f3, 1'b1);
        end else if (f7 == 7'b0000001 && EN_M) begin
          d_aluop = ALUOP_MUL + {2'b00, f3};
        end else begin
          d_ill = 1'b1;
        end
      end
      OPC_FENCE, OPC_SYSTEM: begin
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal words still travel to EX (which traps) but must have no side effects.
    if (d_ill) begin
      d_aluop = ALUOP_ADD;
      d_wreg  = 1'b0;
      d_load  = 1'b0;
      d_br    = BR_NONE;
    end
    if (rd_f == 5'd0) d_wreg = 1'b0;
    d_rd = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : rd_f;
  end

  assign use_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign use_rs2 = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);

  assign hazard = LU_STALL && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                  ((use_rs1 && rs1_addr == ex_rd) || (use_rs2 && rs2_addr == ex_rd));
  assign stall    = hazard || (state == ST_BUBBLE);
  assign if_ready = !flush && !stall && (!ex_valid || ex_ready);
  assign fire     = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      ex_valid   <= 1'b0;
      ex_aluop   <= '0;
      ex_op1     <= IDLE;
      ex_op2     <= IDLE;
      ex_imm     <= IDLE;
      ex_rd      <= '0;
      ex_wreg    <= 1'b0;
      ex_is_load <= 1'b0;
      ex_br_type <= BR_NONE;
      ex_br_tgt  <= '0;
      ex_pc      <= '0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      state    <= ST_RUN;
      ex_valid <= 1'b0;
    end else begin
      if (state == ST_BUBBLE) state <= ST_RUN;
      else if (hazard && ex_ready) state <= ST_BUBBLE;

      if (fire) begin
        ex_valid   <= 1'b1;
        ex_aluop   <= ALUOP_W'(d_aluop);
        ex_op1     <= d_op1;
        ex_op2     <= d_op2;
        ex_imm     <= imm;
        ex_rd      <= d_rd;
        ex_wreg    <= d_wreg;
        ex_is_load <= d_load;
        ex_br_type <= d_br;
        ex_br_tgt  <= d_tgt;
        ex_pc      <= pc;
        ex_illegal <= d_ill;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
